// File: rtl/vec_edge_pkg.sv
// Shared types and default sizing for the vector edge monitor.
// Entry layout in the event FIFO is {mask, stamp}, mask in the upper bits.
package vec_edge_pkg;

    localparam int DEF_WIDTH = 3;
    localparam int DEF_DEPTH = 4;
    localparam int DEF_CNT_W = 8;

    typedef enum logic {
        DISARMED = 1'b0,
        ARMED    = 1'b1
    } mon_state_t;

    function automatic int entry_w(input int width, input int cnt_w);
        return width + cnt_w;
    endfunction

endpackage

// File: rtl/edge_evt_fifo.sv
// Synchronous FIFO for edge records. Pointers carry one extra wrap bit
// so full and empty are told apart without a separate occupancy counter.
module edge_evt_fifo #(
    parameter int DW    = 11,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push_i,
    input  logic [DW-1:0]            data_i,
    output logic                     full_o,
    input  logic                     pop_i,
    output logic [DW-1:0]            data_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d;
    logic [AW:0]   rd_ptr_q, rd_ptr_d;
    logic          wr_en, rd_en;

    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign count_o = wr_ptr_q - rd_ptr_q;
    assign data_o  = mem_q[rd_ptr_q[AW-1:0]];

    // A full FIFO still accepts a write when the head leaves in the same cycle.
    assign rd_en = pop_i && !empty_o;
    assign wr_en = push_i && (!full_o || rd_en);

    // NOTE: every signal written in always_comb gets a default first, so no latch is inferred.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (wr_en) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (rd_en) rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    // NOTE: sequential state uses <= so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // NOTE: storage is reset on purpose -- the head is a visible output that must read 0 out of reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (wr_en) begin
            mem_q[wr_ptr_q[AW-1:0]] <= data_i;
        end
    end

endmodule

// File: rtl/vec_edge_monitor.sv
// Clocked rising-edge monitor for a WIDTH-bit vector: toggles notifier on
// bit-0 rises and queues timestamped {mask, stamp} records for a consumer.
module vec_edge_monitor
    import vec_edge_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] d,
    input  logic             clr,
    output logic             notifier,
    output logic             evt_valid,
    input  logic             evt_ready,
    output logic [WIDTH-1:0] evt_mask,
    output logic [CNT_W-1:0] evt_stamp,
    output logic             overflow,
    output logic [CNT_W-1:0] drop_cnt
);

    localparam int EW = entry_w(WIDTH, CNT_W);
    localparam int AW = $clog2(DEPTH);

    mon_state_t       state_q, state_d;
    logic [WIDTH-1:0] d_q, d_d;
    logic [CNT_W-1:0] stamp_q, stamp_d;
    logic             notifier_q, notifier_d;
    logic             overflow_q, overflow_d;
    logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;

    logic [WIDTH-1:0] rise;
    logic             push, pop, room, push_ok, drop;
    logic             fifo_full, fifo_empty;
    logic [AW:0]      fifo_count;
    logic [EW-1:0]    fifo_head;

    // Arming cycle only captures d, so bits already high at reset release never count.
    always_comb begin
        state_d = state_q;
        d_d     = d;
        rise    = '0;
        case (state_q)
            DISARMED: state_d = ARMED;
            ARMED:    rise    = d & ~d_q;
            default:  state_d = DISARMED;
        endcase
    end

    assign pop     = evt_ready && !fifo_empty;
    assign push    = |rise;
    assign room    = !fifo_full || pop;
    assign push_ok = push && room;
    assign drop    = push && !room;

    always_comb begin
        stamp_d    = stamp_q + CNT_W'(1);
        notifier_d = notifier_q ^ rise[0];
        overflow_d = overflow_q;
        drop_cnt_d = drop_cnt_q;
        if (drop) begin
            // A drop in the same cycle as clr restarts the count at one.
            overflow_d = 1'b1;
            if (clr)                   drop_cnt_d = CNT_W'(1);
            else if (drop_cnt_q != '1) drop_cnt_d = drop_cnt_q + CNT_W'(1);
        end else if (clr) begin
            overflow_d = 1'b0;
            drop_cnt_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= DISARMED;
            d_q        <= '0;
            stamp_q    <= '0;
            notifier_q <= 1'b0;
            overflow_q <= 1'b0;
            drop_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            d_q        <= d_d;
            stamp_q    <= stamp_d;
            notifier_q <= notifier_d;
            overflow_q <= overflow_d;
            drop_cnt_q <= drop_cnt_d;
        end
    end

    edge_evt_fifo #(
        .DW    (EW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push_i  (push_ok),
        .data_i  ({rise, stamp_q}),
        .full_o  (fifo_full),
        .pop_i   (pop),
        .data_o  (fifo_head),
        .empty_o (fifo_empty),
        .count_o (fifo_count)
    );

    assign notifier  = notifier_q;
    assign evt_valid = (fifo_count != '0);
    assign evt_mask  = fifo_head[EW-1:CNT_W];
    assign evt_stamp = fifo_head[CNT_W-1:0];
    assign overflow  = overflow_q;
    assign drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_vec_edge_monitor.sv
// Directed bench for vec_edge_monitor: default instance plus a CNT_W=4
// instance for timestamp wrap; expectations are hand-computed per cycle.
module tb_vec_edge_monitor;

    localparam int W   = 3;
    localparam int CW  = 8;
    localparam int CWS = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [W-1:0]  d = '0;
    logic          clr = 1'b0;
    logic          evt_ready = 1'b0;
    logic          notifier, evt_valid, overflow;
    logic [W-1:0]  evt_mask;
    logic [CW-1:0] evt_stamp, drop_cnt;

    logic           d_clr_s = 1'b0;
    logic [W-1:0]   d_s = '0;
    logic           ready_s = 1'b0;
    logic           notifier_s, valid_s, overflow_s;
    logic [W-1:0]   mask_s;
    logic [CWS-1:0] stamp_s, drop_cnt_s;

    vec_edge_monitor #(.WIDTH(W), .DEPTH(4), .CNT_W(CW)) dut (
        .clk(clk), .rst_n(rst_n), .d(d), .clr(clr),
        .notifier(notifier), .evt_valid(evt_valid), .evt_ready(evt_ready),
        .evt_mask(evt_mask), .evt_stamp(evt_stamp),
        .overflow(overflow), .drop_cnt(drop_cnt)
    );

    vec_edge_monitor #(.WIDTH(W), .DEPTH(4), .CNT_W(CWS)) dut_s (
        .clk(clk), .rst_n(rst_n), .d(d_s), .clr(d_clr_s),
        .notifier(notifier_s), .evt_valid(valid_s), .evt_ready(ready_s),
        .evt_mask(mask_s), .evt_stamp(stamp_s),
        .overflow(overflow_s), .drop_cnt(drop_cnt_s)
    );

    always #5 clk = ~clk;

    int n_vec  = 0;
    int n_miss = 0;
    int edge_n = 0;

    typedef struct {
        logic [W-1:0]  d;
        logic          rdy;
        logic          clr;
        logic          v;
        logic [W-1:0]  m;
        logic [CW-1:0] s;
        logic          n;
        logic          o;
        logic [CW-1:0] dc;
    } vec_t;

    typedef struct {
        logic [W-1:0] pulse;
        int           stamp;
        logic         n;
    } pulse_t;

    vec_t   vecs[$];
    pulse_t pulses[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
        edge_n++;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk);
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
    endtask

    task automatic add(input logic [W-1:0] d_, input logic rdy_, input logic clr_,
                       input logic v_, input logic [W-1:0] m_, input logic [CW-1:0] s_,
                       input logic n_, input logic o_, input logic [CW-1:0] dc_);
        vec_t r;
        r.d = d_; r.rdy = rdy_; r.clr = clr_;
        r.v = v_; r.m = m_; r.s = s_; r.n = n_; r.o = o_; r.dc = dc_;
        vecs.push_back(r);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, " notifier"},  32'(notifier),  32'd0);
        check({tag, " evt_valid"}, 32'(evt_valid), 32'd0);
        check({tag, " evt_mask"},  32'(evt_mask),  32'd0);
        check({tag, " evt_stamp"}, 32'(evt_stamp), 32'd0);
        check({tag, " overflow"},  32'(overflow),  32'd0);
        check({tag, " drop_cnt"},  32'(drop_cnt),  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        //        d       rdy   clr   v     mask    stamp  not   ovf   drop
        add(3'b000, 1'b0, 1'b0, 1'b0, 3'b000, 8'd0,  1'b0, 1'b0, 8'd0);
        add(3'b001, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b0, 8'd0);
        add(3'b010, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b0, 8'd0);
        add(3'b100, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b0, 8'd0);
        add(3'b011, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b0, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b0, 1'b0, 8'd0);
        add(3'b101, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b1, 8'd1);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b1, 8'd1);
        add(3'b110, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b1, 8'd2);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd1,  1'b1, 1'b1, 8'd2);
        add(3'b001, 1'b0, 1'b1, 1'b1, 3'b001, 8'd1,  1'b0, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b0, 1'b1, 3'b010, 8'd3,  1'b0, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b0, 1'b1, 3'b100, 8'd5,  1'b0, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b0, 1'b1, 3'b011, 8'd7,  1'b0, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 8'd0,  1'b0, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b1, 1'b0, 3'b000, 8'd0,  1'b0, 1'b0, 8'd0);
        add(3'b001, 1'b0, 1'b0, 1'b1, 3'b001, 8'd19, 1'b1, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd19, 1'b1, 1'b0, 8'd0);
        add(3'b010, 1'b0, 1'b0, 1'b1, 3'b001, 8'd19, 1'b1, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd19, 1'b1, 1'b0, 8'd0);
        add(3'b100, 1'b0, 1'b0, 1'b1, 3'b001, 8'd19, 1'b1, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd19, 1'b1, 1'b0, 8'd0);
        add(3'b110, 1'b0, 1'b0, 1'b1, 3'b001, 8'd19, 1'b1, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b001, 8'd19, 1'b1, 1'b0, 8'd0);
        add(3'b101, 1'b1, 1'b0, 1'b1, 3'b010, 8'd21, 1'b0, 1'b0, 8'd0);
        add(3'b000, 1'b0, 1'b0, 1'b1, 3'b010, 8'd21, 1'b0, 1'b0, 8'd0);
        add(3'b011, 1'b0, 1'b0, 1'b1, 3'b010, 8'd21, 1'b1, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b0, 1'b1, 3'b100, 8'd23, 1'b1, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b0, 1'b1, 3'b110, 8'd25, 1'b1, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b0, 1'b1, 3'b101, 8'd27, 1'b1, 1'b1, 8'd1);
        add(3'b000, 1'b1, 1'b0, 1'b0, 3'b000, 8'd0,  1'b1, 1'b1, 8'd1);

        pulses[0] = '{3'b001, 10, 1'b1};
        pulses[1] = '{3'b010, 20, 1'b1};
        pulses[2] = '{3'b100, 30, 1'b1};
        pulses[3] = '{3'b110, 40, 1'b1};
        pulses[4] = '{3'b101, 50, 1'b0};
        pulses[5] = '{3'b011, 60, 1'b1};
        pulses[6] = '{3'b111, 70, 1'b0};

        // Reset values while rst_n is held low, bits already high.
        d = 3'b111;
        evt_ready = 1'b1;
        @(negedge clk);
        check_all_zero("reset");
        check("reset slow valid", 32'(valid_s), 32'd0);

        // Bits high through release must not produce events.
        rst_n  = 1'b1;
        edge_n = 0;
        for (int i = 0; i < 10; i++) begin
            cyc();
            check($sformatf("arm hold valid c%0d", i), 32'(evt_valid), 32'd0);
        end
        check("arm hold notifier", 32'(notifier), 32'd0);
        d = 3'b000;
        cyc();
        d = 3'b111;
        cyc();
        check("arm rise valid",    32'(evt_valid), 32'd1);
        check("arm rise mask",     32'(evt_mask),  32'b111);
        check("arm rise stamp",    32'(evt_stamp), 32'd11);
        check("arm rise notifier", 32'(notifier),  32'd1);
        cyc();
        check("arm held no retrigger", 32'(evt_valid), 32'd0);

        // Spaced one-cycle pulses, consumer always ready.
        d = 3'b000;
        evt_ready = 1'b1;
        do_reset();
        for (int p = 0; p < 7; p++) begin
            while (edge_n < pulses[p].stamp) begin
                d = 3'b000;
                cyc();
            end
            d = pulses[p].pulse;
            cyc();
            check($sformatf("pulse%0d valid", p),    32'(evt_valid), 32'd1);
            check($sformatf("pulse%0d mask", p),     32'(evt_mask),  32'(pulses[p].pulse));
            check($sformatf("pulse%0d stamp", p),    32'(evt_stamp), 32'(pulses[p].stamp));
            check($sformatf("pulse%0d notifier", p), 32'(notifier),  32'(pulses[p].n));
            d = 3'b000;
        end
        cyc();
        check("pulse drained", 32'(evt_valid), 32'd0);

        // Overflow, clr-vs-drop, drain order, full with simultaneous pop.
        d = 3'b000;
        evt_ready = 1'b0;
        do_reset();
        foreach (vecs[i]) begin
            d = vecs[i].d;
            evt_ready = vecs[i].rdy;
            clr = vecs[i].clr;
            cyc();
            check($sformatf("v%0d valid", i),    32'(evt_valid), 32'(vecs[i].v));
            if (vecs[i].v) begin
                check($sformatf("v%0d mask", i),  32'(evt_mask),  32'(vecs[i].m));
                check($sformatf("v%0d stamp", i), 32'(evt_stamp), 32'(vecs[i].s));
            end
            check($sformatf("v%0d notifier", i), 32'(notifier), 32'(vecs[i].n));
            check($sformatf("v%0d overflow", i), 32'(overflow), 32'(vecs[i].o));
            check($sformatf("v%0d drop_cnt", i), 32'(drop_cnt), 32'(vecs[i].dc));
        end
        clr = 1'b0;

        // Queue three entries, then reset asynchronously between edges.
        evt_ready = 1'b0;
        d = 3'b010; cyc();
        d = 3'b000; cyc();
        d = 3'b100; cyc();
        d = 3'b000; cyc();
        d = 3'b110; cyc();
        check("mid queued valid",    32'(evt_valid), 32'd1);
        check("mid queued mask",     32'(evt_mask),  32'b010);
        check("mid queued overflow", 32'(overflow),  32'd1);
        d = 3'b001;
        #2 rst_n = 1'b0;
        #1 check_all_zero("mid reset");
        @(negedge clk);
        rst_n  = 1'b1;
        edge_n = 0;
        cyc();
        check("rearm cycle valid",    32'(evt_valid), 32'd0);
        check("rearm cycle notifier", 32'(notifier),  32'd0);
        d = 3'b011;
        cyc();
        check("rearm event valid",    32'(evt_valid), 32'd1);
        check("rearm event mask",     32'(evt_mask),  32'b010);
        check("rearm event stamp",    32'(evt_stamp), 32'd1);
        check("rearm event notifier", 32'(notifier),  32'd0);

        // Four-bit stamp wraps between captures at 14 and 17.
        d = 3'b000;
        d_s = 3'b000;
        ready_s = 1'b0;
        do_reset();
        while (edge_n < 14) cyc();
        d_s = 3'b001; cyc();
        d_s = 3'b000; cyc();
        cyc();
        d_s = 3'b010; cyc();
        d_s = 3'b000;
        check("wrap first valid", 32'(valid_s), 32'd1);
        check("wrap first mask",  32'(mask_s),  32'b001);
        check("wrap first stamp", 32'(stamp_s), 32'd14);
        ready_s = 1'b1;
        cyc();
        check("wrap second mask",  32'(mask_s),  32'b010);
        check("wrap second stamp", 32'(stamp_s), 32'd1);
        cyc();
        check("wrap drained", 32'(valid_s), 32'd0);
        ready_s = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
